// File: rtl/pipeline_ctrl_if.sv
// Stall/exception bus between the pipeline stages, MEM/CP0 and the pipeline controller.
// master = pipeline side driving requests and exception info; slave = controller.
interface pipeline_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] exc_type_i;
  logic [31:0] exc_pc_i;
  logic        exc_in_delayslot_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        epc_wr_o;
  logic [31:0] epc_o;
  logic [4:0]  cause_code_o;
  logic        stall_timeout_o;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output exc_type_i, exc_pc_i, exc_in_delayslot_i, cp0_epc_i,
    input  stall_o, flush_o, new_pc_o, epc_wr_o, epc_o, cause_code_o, stall_timeout_o
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  exc_type_i, exc_pc_i, exc_in_delayslot_i, cp0_epc_i,
    output stall_o, flush_o, new_pc_o, epc_wr_o, epc_o, cause_code_o, stall_timeout_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences exception/ERET redirects
// (freeze, then flush with new PC and EPC/cause capture) and runs a stall watchdog.
module pipeline_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h8000_0180,
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst,
  pipeline_ctrl_if.slave   bus
);

  localparam int unsigned FcW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned WdW = $clog2(STALL_TIMEOUT + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(STALL_TIMEOUT);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e         state_q;
  logic [FcW-1:0] flush_cnt_q;
  logic [WdW-1:0] wd_cnt_q;
  logic [WdW-1:0] wd_inc;
  logic           flush_q;
  logic [31:0]    new_pc_q;
  logic           epc_wr_q;
  logic [31:0]    epc_q;
  logic [4:0]     cause_q;
  logic           timeout_q;

  logic exc_inv, exc_sys, exc_eret, exc_any, any_req;
  logic [5:0] stall;

  assign exc_inv  = bus.exc_type_i[9];
  assign exc_sys  = bus.exc_type_i[8];
  assign exc_eret = bus.exc_type_i[12];
  assign exc_any  = exc_inv | exc_sys | exc_eret;
  assign any_req  = bus.stallreq_if | bus.stallreq_id | bus.stallreq_ex | bus.stallreq_mem;
  assign wd_inc   = (wd_cnt_q == WdMax) ? wd_cnt_q : wd_cnt_q + 1'b1;

  // Deepest requesting stage wins; an exception freezes everything while it is latched.
  always_comb begin
    stall = 6'b000000;
    if (state_q == StRun) begin
      if (exc_any)               stall = 6'b111111;
      else if (bus.stallreq_mem) stall = 6'b011111;
      else if (bus.stallreq_ex)  stall = 6'b001111;
      else if (bus.stallreq_id)  stall = 6'b000111;
      else if (bus.stallreq_if)  stall = 6'b000011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      wd_cnt_q    <= '0;
      flush_q     <= 1'b0;
      new_pc_q    <= 32'd0;
      epc_wr_q    <= 1'b0;
      epc_q       <= 32'd0;
      cause_q     <= 5'd0;
      timeout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          epc_wr_q <= 1'b0;
          if (any_req) begin
            wd_cnt_q <= wd_inc;
            if (wd_inc == WdMax) timeout_q <= 1'b1;
          end else begin
            wd_cnt_q <= '0;
          end
          if (exc_any) begin
            state_q     <= StFlush;
            flush_q     <= 1'b1;
            flush_cnt_q <= FcW'(FLUSH_CYCLES - 1);
            if (exc_inv || exc_sys) begin
              new_pc_q <= EXC_VECTOR;
              epc_wr_q <= 1'b1;
              epc_q    <= bus.exc_in_delayslot_i ? bus.exc_pc_i - 32'd4 : bus.exc_pc_i;
              cause_q  <= exc_inv ? 5'd10 : 5'd8;
            end else begin
              new_pc_q <= bus.cp0_epc_i;
            end
          end
        end
        StFlush: begin
          epc_wr_q <= 1'b0;
          wd_cnt_q <= '0;
          if (flush_cnt_q == '0) begin
            state_q <= StRun;
            flush_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.stall_o         = stall;
  assign bus.flush_o         = flush_q;
  assign bus.new_pc_o        = new_pc_q;
  assign bus.epc_wr_o        = epc_wr_q;
  assign bus.epc_o           = epc_q;
  assign bus.cause_code_o    = cause_q;
  assign bus.stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: two controllers (default params, and FLUSH_CYCLES=3/STALL_TIMEOUT=4)
// share stimulus; a cycle-level reference model queues expected outputs for a monitor.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        epc_wr;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        tout;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0]  req;  // {mem, ex, id, if}
  logic [31:0] et, pc, cp0_epc;
  logic        ds;

  always #5 clk = ~clk;

  pipeline_ctrl_if ifa ();
  pipeline_ctrl_if ifb ();

  assign ifa.stallreq_if = req[0];
  assign ifa.stallreq_id = req[1];
  assign ifa.stallreq_ex = req[2];
  assign ifa.stallreq_mem = req[3];
  assign ifa.exc_type_i = et;
  assign ifa.exc_pc_i = pc;
  assign ifa.exc_in_delayslot_i = ds;
  assign ifa.cp0_epc_i = cp0_epc;
  assign ifb.stallreq_if = req[0];
  assign ifb.stallreq_id = req[1];
  assign ifb.stallreq_ex = req[2];
  assign ifb.stallreq_mem = req[3];
  assign ifb.exc_type_i = et;
  assign ifb.exc_pc_i = pc;
  assign ifb.exc_in_delayslot_i = ds;
  assign ifb.cp0_epc_i = cp0_epc;

  pipeline_ctrl dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pipeline_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int          fc_p[2] = '{1, 3};
  int          to_p[2] = '{1024, 4};
  int          flush_left[2];
  int          run_len[2];
  logic        tout_m[2];
  logic [31:0] npc_m[2];
  logic [31:0] epc_m[2];
  logic [4:0]  cause_m[2];
  logic        ewr_m[2];

  exp_t qa[$];
  exp_t qb[$];

  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [5:0] deepest(input logic [3:0] r);
    if (r[3]) return 6'b011111;
    if (r[2]) return 6'b001111;
    if (r[1]) return 6'b000111;
    if (r[0]) return 6'b000011;
    return 6'b000000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      flush_left[i] = 0;
      run_len[i] = 0;
      tout_m[i] = 1'b0;
      npc_m[i] = 32'd0;
      epc_m[i] = 32'd0;
      cause_m[i] = 5'd0;
      ewr_m[i] = 1'b0;
    end
  endtask

  // Apply one cycle of stimulus, queue what each DUT should show this cycle, advance model.
  task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] t,
                      input logic [31:0] p, input logic d, input logic [31:0] ce);
    exp_t e;
    logic inv, sys, ert;
    rst = r; req = rq; et = t; pc = p; ds = d; cp0_epc = ce;
    inv = t[9]; sys = t[8]; ert = t[12];
    for (int i = 0; i < 2; i++) begin
      e.flush = (flush_left[i] > 0);
      e.stall = (flush_left[i] > 0) ? 6'd0 : ((inv | sys | ert) ? 6'h3F : deepest(rq));
      e.new_pc = npc_m[i];
      e.epc_wr = ewr_m[i];
      e.epc = epc_m[i];
      e.cause = cause_m[i];
      e.tout = tout_m[i];
      if (i == 0) qa.push_back(e);
      else qb.push_back(e);
      if (r) begin
        flush_left[i] = 0; run_len[i] = 0; tout_m[i] = 1'b0; npc_m[i] = 32'd0;
        epc_m[i] = 32'd0; cause_m[i] = 5'd0; ewr_m[i] = 1'b0;
      end else if (flush_left[i] > 0) begin
        flush_left[i]--;
        run_len[i] = 0;
        ewr_m[i] = 1'b0;
      end else begin
        ewr_m[i] = 1'b0;
        if (rq != 4'd0) begin
          if (run_len[i] < to_p[i]) run_len[i]++;
          if (run_len[i] == to_p[i]) tout_m[i] = 1'b1;
        end else begin
          run_len[i] = 0;
        end
        if (inv | sys | ert) begin
          flush_left[i] = fc_p[i];
          if (inv | sys) begin
            npc_m[i] = 32'h8000_0180;
            ewr_m[i] = 1'b1;
            epc_m[i] = d ? p - 32'd4 : p;
            cause_m[i] = inv ? 5'd10 : 5'd8;
          end else begin
            npc_m[i] = ce;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic cmp(input string nm, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %h, expected %h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic check(input int inst, input exp_t e, input exp_t a);
    cmp("stall_o", inst, 32'(a.stall), 32'(e.stall));
    cmp("flush_o", inst, 32'(a.flush), 32'(e.flush));
    cmp("new_pc_o", inst, a.new_pc, e.new_pc);
    cmp("epc_wr_o", inst, 32'(a.epc_wr), 32'(e.epc_wr));
    cmp("epc_o", inst, a.epc, e.epc);
    cmp("cause_code_o", inst, 32'(a.cause), 32'(e.cause));
    cmp("stall_timeout_o", inst, 32'(a.tout), 32'(e.tout));
  endtask

  // Monitor: every cycle both DUTs present outputs; compare against queued expectations.
  initial begin
    exp_t a;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        a = '{ifa.stall_o, ifa.flush_o, ifa.new_pc_o, ifa.epc_wr_o, ifa.epc_o,
              ifa.cause_code_o, ifa.stall_timeout_o};
        check(0, qa.pop_front(), a);
      end
      if (qb.size() > 0) begin
        a = '{ifb.stall_o, ifb.flush_o, ifb.new_pc_o, ifb.epc_wr_o, ifb.epc_o,
              ifb.cause_code_o, ifb.stall_timeout_o};
        check(1, qb.pop_front(), a);
      end
    end
  end

  initial begin
    logic [31:0] kinds [6];
    logic [31:0] t;
    kinds = '{32'h100, 32'h200, 32'h300, 32'h1000, 32'h1100, 32'h1200};
    rst = 1'b1; req = 4'd0; et = 32'd0; pc = 32'd0; ds = 1'b0; cp0_epc = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, then merged stall requests
    idle(1);
    step(1'b0, 4'b0110, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 4'b0001, 32'd0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 4'b1111, 32'd0, 32'd0, 1'b0, 32'd0);
    idle(1);
    // Syscall, invalid in delay slot, invalid+syscall priority
    step(1'b0, 4'b0010, 32'h100, 32'h8000_0040, 1'b0, 32'd0);
    idle(4);
    step(1'b0, 4'b0000, 32'h200, 32'h8000_0044, 1'b1, 32'd0);
    idle(4);
    step(1'b0, 4'b1000, 32'h300, 32'h8000_0100, 1'b0, 32'd0);
    idle(4);
    // ERET, then an exception two cycles later (ignored by the long-flush DUT)
    step(1'b0, 4'b0000, 32'h1000, 32'h0, 1'b0, 32'h8000_1234);
    idle(1);
    step(1'b0, 4'b0000, 32'h100, 32'h8000_0200, 1'b0, 32'd0);
    idle(5);
    // Delay slot at PC 0 wraps modulo 2^32
    step(1'b0, 4'b0000, 32'h200, 32'h0, 1'b1, 32'd0);
    idle(4);
    // Watchdog: held MEM stall, then reset and 3-on/1-off bursts
    for (int k = 0; k < 4; k++) step(1'b0, 4'b1000, 32'd0, 32'd0, 1'b0, 32'd0);
    idle(3);
    step(1'b1, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 3; k++) step(1'b0, 4'b0100, 32'd0, 32'd0, 1'b0, 32'd0);
      idle(1);
    end
    // Reset in the first flush cycle
    step(1'b0, 4'b0000, 32'h100, 32'h8000_0300, 1'b0, 32'd0);
    step(1'b1, 4'b0000, 32'd0, 32'd0, 1'b0, 32'd0);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      t = $urandom & ~32'h0000_1300;
      if ($urandom_range(0, 7) == 0) t = t | kinds[$urandom_range(0, 5)];
      step(($urandom_range(0, 99) == 0), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
           t, $urandom, 1'($urandom_range(0, 1)), $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
